// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// frame state encoding and line levels.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_tick_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled and pulses tick on the
// terminal count. clr restarts the count so every frame begins on a bit boundary.
module bit_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && !clr && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial framed transmitter: start, WIDTH data bits LSB first,
// optional even parity (SERIAL_TX_PARITY_EN), stop. All outputs registered.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
  output logic             Ready,
  output logic             SerOut,
  output logic             Busy,
  output tx_state_t        dbg_state
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  // Handshake: a word is taken on the rising edge where Load and Ready are both
  // high; Load while Ready is low is dropped, never queued.
  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             ser_q, ser_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             tick;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  bit_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .Clk  (Clk),
    .Reset(Reset),
    .clr  (accept),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  always_comb begin
    accept  = Load && ready_q;
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = Data;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^Data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so SerOut comes straight off a flop.
    case (state_d)
      START:   ser_d = START_LEVEL;
      DATA:    ser_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  ser_d = par_d;
`endif
      STOP:    ser_d = STOP_LEVEL;
      default: ser_d = IDLE_LEVEL;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      ser_q   <= IDLE_LEVEL;
      ready_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
      ready_q <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Ready     = ready_q;
  assign Busy      = ~ready_q;
  assign SerOut    = ser_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: an 8-bit/div-4 instance and a 1-bit/div-1 instance.
module tb_serial_tx;
  import serial_pkg::*;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int DIV       = 4;
  localparam int FRAME_CYC = NBITS * DIV;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] Data = 8'h00;
  logic       Ready, SerOut, Busy;
  tx_state_t  dbg_state;

  logic       Load1 = 1'b0;
  logic [0:0] Data1 = 1'b0;
  logic       Ready1, SerOut1, Busy1;
  tx_state_t  dbg_state1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_tx #(.WIDTH(8), .CLK_DIV(DIV)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Data(Data),
    .Ready(Ready), .SerOut(SerOut), .Busy(Busy), .dbg_state(dbg_state)
  );

  serial_tx #(.WIDTH(1), .CLK_DIV(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Load(Load1), .Data(Data1),
    .Ready(Ready1), .SerOut(SerOut1), .Busy(Busy1), .dbg_state(dbg_state1)
  );

  // Clock / reset: posedge at 5, 15, ...; bench samples and drives on negedges.
  initial forever #5 Clk = ~Clk;

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef SERIAL_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic check_out(input string name, input logic ser, input logic rdy, input int cyc);
    n_checks++;
    if (SerOut !== ser || Ready !== rdy || Busy !== ~rdy) begin
      n_fail++;
      $display("FAIL %s cyc %0d: SerOut=%b Ready=%b Busy=%b, expected SerOut=%b Ready=%b Busy=%b",
               name, cyc, SerOut, Ready, Busy, ser, rdy, ~rdy);
    end
  endtask

  // Called on a negedge with Ready expected high; returns on the first negedge after the accept edge.
  task automatic start_frame(input logic [7:0] d, input string name);
    Load = 1'b1;
    Data = d;
    check_out({name, "_pre"}, 1'b1, 1'b1, -1);
    @(negedge Clk);
    Load = 1'b0;
    Data = ~d;
  endtask

  // Checks every cycle of one frame and the idle cycle after it. inject >= 0
  // raises Load with 8'hFF for one cycle at that offset.
  task automatic expect_frame(input logic [7:0] d, input string name, input int inject);
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (inject >= 0 && c == inject) begin
        Load = 1'b1;
        Data = 8'hFF;
      end else if (inject >= 0 && c == inject + 1) begin
        Load = 1'b0;
      end
      check_out(name, exp_bit(d, c / DIV), 1'b0, c);
      @(negedge Clk);
    end
    check_out({name, "_end"}, 1'b1, 1'b1, FRAME_CYC);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    check_out("reset", 1'b1, 1'b1, 0);
    n_checks++;
    if (dbg_state !== IDLE || SerOut1 !== 1'b1 || Ready1 !== 1'b1 || Busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d ser1=%b rdy1=%b busy1=%b, expected 0 1 1 0",
               dbg_state, SerOut1, Ready1, Busy1);
    end
    Reset = 1'b1;
    @(negedge Clk);
    check_out("reset_release", 1'b1, 1'b1, 1);
  endtask

  task automatic test_basic();
    start_frame(8'hA5, "basic");
    expect_frame(8'hA5, "basic_a5", -1);
    @(negedge Clk);
    start_frame(8'h5A, "basic2");
    expect_frame(8'h5A, "basic_5a", -1);
  endtask

  task automatic test_ignored();
    @(negedge Clk);
    start_frame(8'h96, "ign");
    expect_frame(8'h96, "ignored", 30);
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      check_out("ignored_idle", 1'b1, 1'b1, c);
    end
  endtask

  task automatic test_back_to_back();
    Load = 1'b1;
    Data = 8'h3C;
    @(negedge Clk);
    Data = 8'hC3;
    expect_frame(8'h3C, "b2b_first", -1);
    @(negedge Clk);
    Load = 1'b0;
    expect_frame(8'hC3, "b2b_second", -1);
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    @(negedge Clk);
    start_frame(8'hA5, "par");
    expect_frame(8'hA5, "parity_a5", -1);
    @(negedge Clk);
    start_frame(8'h07, "par");
    expect_frame(8'h07, "parity_07", -1);
  endtask
`endif

  task automatic test_abort();
    @(negedge Clk);
    start_frame(8'h52, "abort");
    repeat (17) @(negedge Clk);
    n_checks++;
    if (dbg_state !== DATA) begin
      n_fail++;
      $display("FAIL abort_state: state=%0d expected %0d", dbg_state, DATA);
    end
    check_out("abort_bit3", 1'b0, 1'b0, 17);
    #2 Reset = 1'b0;
    #1 check_out("abort_async", 1'b1, 1'b1, 0);
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL abort_idle: state=%0d expected %0d", dbg_state, IDLE);
    end
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    start_frame(8'h01, "after_abort");
    expect_frame(8'h01, "after_abort", -1);
  endtask

  task automatic test_min_width();
    logic exp_seq[$];
    for (int v = 0; v < 2; v++) begin
      exp_seq = {1'b0, v[0]};
`ifdef SERIAL_TX_PARITY_EN
      exp_seq.push_back(v[0]);
`endif
      exp_seq.push_back(1'b1);
      @(negedge Clk);
      Load1 = 1'b1;
      Data1 = v[0];
      @(negedge Clk);
      Load1 = 1'b0;
      Data1 = ~v[0];
      for (int c = 0; c < exp_seq.size(); c++) begin
        n_checks++;
        if (SerOut1 !== exp_seq[c] || Ready1 !== 1'b0) begin
          n_fail++;
          $display("FAIL min_width d=%0d cyc %0d: SerOut=%b Ready=%b, expected %b 0",
                   v, c, SerOut1, Ready1, exp_seq[c]);
        end
        @(negedge Clk);
      end
      n_checks++;
      if (SerOut1 !== 1'b1 || Ready1 !== 1'b1 || Busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL min_width_end d=%0d: SerOut=%b Ready=%b Busy=%b, expected 1 1 0",
                 v, SerOut1, Ready1, Busy1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored();
    test_back_to_back();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    test_abort();
    test_min_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
